// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch state encoding and word/address defaults shared by the fetch unit and the cpu top.
package cpu_pkg;
    typedef enum logic [1:0] {FETCH, HOLD, HALTED, FAULT} fetch_state_t;
    localparam int INSN_BYTES = 4;
    localparam int XLEN = 32;
    localparam int IMEM_AW = 10;
endpackage

// File: rtl/ifetch_assembler.sv
// ifetch_assembler: little-endian assembly of one instruction word from sequential bytes.
module ifetch_assembler
    import cpu_pkg::*;
#(
    parameter int N = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [7:0]   byte_i,
    output logic [N-1:0] word_o,
    output logic         last_o
);
    localparam logic [1:0] LAST = 2'(INSN_BYTES - 1);
    logic [1:0]   cnt_q;
    logic [N-1:0] word_q;
    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (en_i) begin
            word_q[{cnt_q, 3'b000} +: 8] <= byte_i;
            cnt_q <= cnt_q + 2'd1;
        end
    end
    assign word_o = word_q;
    assign last_o = cnt_q == LAST;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: byte-serial instruction fetch over a 1-cycle-latency memory with a valid/ready output.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirects in the FAULT state.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int N = XLEN,
    parameter int M = IMEM_AW,
    parameter logic [M+1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    output logic         mem_en,
    output logic [M+1:0] mem_addr,
    input  logic [7:0]   mem_rdata,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_instr,
    output logic [M+1:0] out_pc,
    input  logic         redirect_valid,
    input  logic [M+1:0] redirect_pc,
    input  logic         halt,
    output logic         is_halted,
    output logic         fault
);
    localparam int AW = M + 2;
    fetch_state_t  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [2:0]    req_q, req_d;
    logic          cap, asm_last, misaligned;
    // A byte lands one cycle after each request, so capture lags the request counter by one.
    assign cap = state_q == FETCH && req_q != 3'd0;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign misaligned = redirect_pc[1:0] != 2'b00;
    assign fault = state_q == FAULT;
`else
    assign misaligned = 1'b0;
    assign fault = 1'b0;
`endif
    ifetch_assembler #(.N(N)) u_asm (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (halt || redirect_valid),
        .en_i   (cap),
        .byte_i (mem_rdata),
        .word_o (out_instr),
        .last_o (asm_last)
    );
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        req_d = req_q;
        if (state_q == FETCH || state_q == HOLD) begin
            if (halt) begin
                state_d = HALTED;
            end else if (redirect_valid) begin
                state_d = misaligned ? FAULT : FETCH;
                pc_d = redirect_pc & ~AW'(3);
                req_d = 3'd0;
            end else if (state_q == FETCH) begin
                req_d = req_q == 3'd4 ? req_q : req_q + 3'd1;
                state_d = cap && asm_last ? HOLD : FETCH;
            end else if (out_ready) begin
                state_d = FETCH;
                pc_d = pc_q + AW'(INSN_BYTES);
                req_d = 3'd0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q <= RESET_PC;
            req_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            req_q <= req_d;
        end
    end
    // Gating with rst makes the first request coincide with the first cycle out of reset.
    assign mem_en = rst && state_q == FETCH && req_q != 3'd4;
    assign mem_addr = pc_q + AW'(req_q);
    assign out_valid = state_q == HOLD;
    assign out_pc = out_valid ? pc_q : '0;
    assign is_halted = state_q == HALTED || state_q == FAULT;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a byte-array memory model.
module tb_instr_fetch;
    localparam int AW = 12;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rst_w = 1'b0;
    logic          mem_en, out_valid, is_halted, fault;
    logic [AW-1:0] mem_addr, out_pc;
    logic [7:0]    mem_rdata = '0;
    logic [31:0]   out_instr;
    logic          out_ready = 1'b0, redirect_valid = 1'b0, halt = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          w_mem_en, w_out_valid, w_is_halted, w_fault;
    logic [AW-1:0] w_mem_addr, w_out_pc;
    logic [7:0]    w_mem_rdata = '0;
    logic [31:0]   w_out_instr;
    logic [7:0]    mem [0:4095];
    logic [7:0]    wmem [0:4095];
    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] pc, tgt;

    instr_fetch #(.N(32), .M(10), .RESET_PC(12'h000)) u_dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .is_halted(is_halted), .fault(fault)
    );

    instr_fetch #(.N(32), .M(10), .RESET_PC(12'hFFC)) u_wrap (
        .clk(clk), .rst(rst_w), .mem_en(w_mem_en), .mem_addr(w_mem_addr), .mem_rdata(w_mem_rdata),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_instr(w_out_instr), .out_pc(w_out_pc),
        .redirect_valid(1'b0), .redirect_pc(12'h000), .halt(1'b0),
        .is_halted(w_is_halted), .fault(w_fault)
    );

    always #5 clk = ~clk;

    // Memory answers one cycle after a request and returns junk otherwise.
    always @(posedge clk) begin
        mem_rdata <= mem_en ? mem[mem_addr] : 8'($urandom);
        w_mem_rdata <= w_mem_en ? wmem[w_mem_addr] : 8'($urandom);
    end

    function automatic logic [31:0] word_at(input bit w, input logic [AW-1:0] a);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w ? wmem[a + AW'(i)] : mem[a + AW'(i)];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at cycle 0 of a fetch; returns in the first cycle the word is presented.
    task automatic expect_fetch(input logic [AW-1:0] a);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            chk("fetch_addr", {mem_en, out_valid, mem_addr}, {2'b10, a + AW'(k)});
        end
        @(negedge clk);
        chk("fetch_gap", {out_valid, mem_en}, 2'b00);
        @(negedge clk);
        chk("out_valid", out_valid, 1'b1);
        chk("out_instr", out_instr, word_at(1'b0, a));
        chk("out_pc", out_pc, a);
    endtask

    task automatic hold(input int n, input logic [AW-1:0] a);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("hold", {out_valid, mem_en, out_instr, out_pc}, {2'b10, word_at(1'b0, a), a});
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [AW-1:0] a, input logic rdy);
        redirect_valid = 1'b1;
        redirect_pc = a;
        out_ready = rdy;
        @(negedge clk);
        redirect_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'($urandom);
            wmem[i] = 8'($urandom);
        end
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 12'h000);
        chk("rst_halted", is_halted, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_wrap", {w_mem_en, w_out_valid, w_is_halted, w_fault}, 4'b0000);
        rst = 1'b1;
        #1;
        expect_fetch(12'h000);
        chk("first_word", out_instr, 32'h0000_0013);
        accept();
        expect_fetch(12'h004);
        hold(10, 12'h004);
        accept();
        pc = 12'h008;
        for (int it = 0; it < 5; it++) begin
            expect_fetch(pc);
            hold($urandom_range(0, 3), pc);
            accept();
            pc = pc + 12'd4;
        end
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            chk("abort_addr", {mem_en, mem_addr}, {1'b1, pc + AW'(k)});
        end
        pulse_redirect(12'h100, 1'b0);
        expect_fetch(12'h100);
        for (int it = 0; it < 4; it++) begin
            tgt = AW'($urandom) & ~AW'(3);
            pulse_redirect(tgt, 1'b0);
            expect_fetch(tgt);
            accept();
            repeat ($urandom_range(0, 4)) @(negedge clk);
            tgt = AW'($urandom) & ~AW'(3);
            pulse_redirect(tgt, 1'b0);
            expect_fetch(tgt);
        end
        tgt = AW'($urandom) & ~AW'(3);
        pulse_redirect(tgt, 1'b1);
        expect_fetch(tgt);
        pulse_redirect(12'h102, 1'b0);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("fault_enter", {fault, is_halted, out_valid, mem_en}, 4'b1100);
        for (int i = 0; i < 5; i++) begin
            halt = 1'($urandom);
            redirect_valid = 1'($urandom);
            redirect_pc = AW'($urandom);
            @(negedge clk);
            chk("fault_stay", {fault, is_halted, out_valid, mem_en}, 4'b1100);
        end
        halt = 1'b0;
        redirect_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_fetch(12'h000);
`else
        expect_fetch(12'h100);
`endif
        accept();
        @(negedge clk);
        halt = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 12'h200;
        @(negedge clk);
        halt = 1'b0;
        redirect_valid = 1'b0;
        chk("halt_enter", {is_halted, fault, out_valid, mem_en}, 4'b1000);
        for (int i = 0; i < 20; i++) begin
            halt = 1'($urandom);
            redirect_valid = 1'($urandom);
            redirect_pc = AW'($urandom) & ~AW'(3);
            @(negedge clk);
            chk("halt_stay", {is_halted, fault, out_valid, mem_en}, 4'b1000);
        end
        halt = 1'b0;
        redirect_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("halt_reset", {is_halted, out_valid, mem_en}, 3'b000);
        rst = 1'b1;
        #1;
        expect_fetch(12'h000);
        rst_w = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            chk("wrap_addr", {w_mem_en, w_mem_addr}, {1'b1, 12'hFFC + AW'(k)});
        end
        repeat (2) @(negedge clk);
        chk("wrap_word0", {w_out_valid, w_out_pc, w_out_instr}, {1'b1, 12'hFFC, word_at(1'b1, 12'hFFC)});
        @(negedge clk);
        chk("wrap_next_addr", {w_mem_en, w_mem_addr}, {1'b1, 12'h000});
        repeat (5) @(negedge clk);
        chk("wrap_word1", {w_out_valid, w_out_pc, w_out_instr}, {1'b1, 12'h000, word_at(1'b1, 12'h000)});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
